// File: rtl/mcycle_pkg.sv
// Shared bus-op encodings and default parameter constants for the M-cycle sequencer.
package mcycle_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_FETCH = 2'b01,
        OP_WRITE = 2'b10,
        OP_READ  = 2'b11
    } bus_op_e;

    localparam int DEF_AW       = 16;
    localparam int DEF_DW       = 8;
    localparam int DEF_TSTATES  = 4;
    localparam int DEF_MAX_WAIT = 15;

endpackage

// File: rtl/mcycle_seq_tstate_ctr.sv
// Free-running T-state counter: counts 0..TSTATES-1 and wraps, freezing while hold is high.
module tstate_ctr
    import mcycle_pkg::*;
#(
    parameter int TSTATES = DEF_TSTATES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    output logic [3:0] t_state
);

    localparam logic [3:0] LAST = 4'(TSTATES - 1);

    logic [3:0] t_next;

    always_comb begin
        t_next = t_state;
        if (!hold) begin
            t_next = (t_state == LAST) ? 4'd0 : t_state + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state <= 4'd0;
        end else begin
            t_state <= t_next;
        end
    end

endmodule

// File: rtl/mcycle_seq.sv
// M-cycle bus sequencer: drives address, strobes and data per T-state.
// Wait-state support (ready input, timeout, bus_err) is built only when MCYCLE_SEQ_WAIT_EN is defined.
module mcycle_seq
    import mcycle_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int TSTATES  = DEF_TSTATES,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] din,
    input  logic          ready,
    output logic          phi,
    output logic [AW-1:0] a,
    output logic [DW-1:0] dout,
    output logic          rd,
    output logic          wr,
    output logic [DW-1:0] rdata,
    output logic          fetch_vld,
    output logic          read_vld,
    output logic [3:0]    t_state,
    output logic          m_end,
    output logic          bus_err
);

    localparam logic [3:0] S     = 4'(TSTATES - 2);
    localparam logic [3:0] S_PRE = 4'(TSTATES - 3);
    localparam logic [3:0] LAST  = 4'(TSTATES - 1);

    logic          hold;
    logic          in_pre;
    logic          leave_t0;
    logic          enter_s;
    logic          enter_last;
    logic [1:0]    op_l;
    logic [DW-1:0] wdata_l;

    tstate_ctr #(.TSTATES(TSTATES)) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (hold),
        .t_state (t_state)
    );

    assign in_pre     = (t_state == S_PRE);
    assign leave_t0   = (t_state == 4'd0);
    assign enter_s    = in_pre && !hold;
    assign enter_last = (t_state == S);
    assign m_end      = (t_state == LAST);

`ifdef MCYCLE_SEQ_WAIT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    // Once MAX_WAIT waits have been inserted the cycle is forced on as if ready were high.
    assign timeout = (wait_cnt == 8'(MAX_WAIT));
    assign hold    = in_pre && !ready && !timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
        end else begin
            if (leave_t0) begin
                wait_cnt <= 8'd0;
            end else if (hold) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (in_pre && !ready && timeout) begin
                bus_err <= 1'b1;
            end
        end
    end
`else
    logic [7:0] unused_wait;

    assign unused_wait = 8'(MAX_WAIT) ^ {8{ready}};
    assign hold        = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi       <= 1'b0;
            a         <= '0;
            dout      <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            rdata     <= '0;
            fetch_vld <= 1'b0;
            read_vld  <= 1'b0;
            op_l      <= 2'b00;
            wdata_l   <= '0;
        end else begin
            fetch_vld <= 1'b0;
            read_vld  <= 1'b0;
            if (leave_t0) begin
                a       <= addr;
                op_l    <= op;
                wdata_l <= wdata;
                rd      <= (op == OP_FETCH) || (op == OP_READ);
                wr      <= 1'b0;
                phi     <= 1'b1;
            end
            if (enter_s) begin
                phi <= 1'b0;
                rd  <= 1'b0;
                case (op_l)
                    OP_WRITE: begin
                        wr   <= 1'b1;
                        dout <= wdata_l;
                    end
                    OP_FETCH: begin
                        rdata     <= din;
                        fetch_vld <= 1'b1;
                    end
                    OP_READ: begin
                        rdata    <= din;
                        read_vld <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (enter_last) begin
                wr   <= 1'b0;
                dout <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_seq.sv
// Directed bench for mcycle_seq: default-parameter instance plus a TSTATES=6 / MAX_WAIT=2 instance.
module tb_mcycle_seq;

    logic        clk;
    logic        rst_n;

    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata, din;
    logic        ready;
    logic        phi, rd, wr, fetch_vld, read_vld, m_end, bus_err;
    logic [15:0] a;
    logic [7:0]  dout, rdata;
    logic [3:0]  t_state;

    logic [1:0]  op2;
    logic [15:0] addr2;
    logic [7:0]  wdata2, din2;
    logic        ready2;
    logic        phi2, rd2, wr2, fetch_vld2, read_vld2, m_end2, bus_err2;
    logic [15:0] a2;
    logic [7:0]  dout2, rdata2;
    logic [3:0]  t_state2;

    int n_checks = 0;
    int n_fail   = 0;

    mcycle_seq u_dut (
        .clk(clk), .rst_n(rst_n), .op(op), .addr(addr), .wdata(wdata), .din(din),
        .ready(ready), .phi(phi), .a(a), .dout(dout), .rd(rd), .wr(wr), .rdata(rdata),
        .fetch_vld(fetch_vld), .read_vld(read_vld), .t_state(t_state), .m_end(m_end),
        .bus_err(bus_err)
    );

    mcycle_seq #(.TSTATES(6), .MAX_WAIT(2)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .op(op2), .addr(addr2), .wdata(wdata2), .din(din2),
        .ready(ready2), .phi(phi2), .a(a2), .dout(dout2), .rd(rd2), .wr(wr2), .rdata(rdata2),
        .fetch_vld(fetch_vld2), .read_vld(read_vld2), .t_state(t_state2), .m_end(m_end2),
        .bus_err(bus_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync1();
        for (int i = 0; i < 20 && t_state != 4'd0; i++) step();
        check("sync1_t0", 32'(t_state), 32'd0);
    endtask

    task automatic sync2();
        for (int i = 0; i < 20 && t_state2 != 4'd0; i++) step();
        check("sync2_t0", 32'(t_state2), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic        exp_rd;
        logic        exp_wr;
        logic [7:0]  exp_dout;
        logic [7:0]  exp_rdata;
        logic        exp_fvld;
        logic        exp_rvld;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'b01, 16'h0150, 8'h00, 8'h3E, 1'b1, 1'b0, 8'h00, 8'h3E, 1'b1, 1'b0};
        vecs[1] = '{2'b10, 16'hFF80, 8'hA5, 8'h77, 1'b0, 1'b1, 8'hA5, 8'h3E, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 16'h1234, 8'h00, 8'hC3, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b1};
        vecs[3] = '{2'b00, 16'hBEEF, 8'h99, 8'h11, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 16'hFFFF, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 16'h0000, 8'h00, 8'hEE, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 16'hAAAA, 8'h5F, 8'hFF, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1};

        rst_n = 1'b0;
        op = 2'b00; addr = 16'h0; wdata = 8'h0; din = 8'h0; ready = 1'b1;
        op2 = 2'b00; addr2 = 16'h0; wdata2 = 8'h0; din2 = 8'h0; ready2 = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_t_state", 32'(t_state), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_rd_wr_phi", {29'd0, rd, wr, phi}, 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_flags", {28'd0, fetch_vld, read_vld, m_end, bus_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Table of single M-cycles on the default instance
        for (int i = 0; i < 7; i++) begin
            check($sformatf("v%0d_t0", i), 32'(t_state), 32'd0);
            op = vecs[i].op; addr = vecs[i].addr; wdata = vecs[i].wdata; din = vecs[i].din;
            step();
            check($sformatf("v%0d_t1_state", i), 32'(t_state), 32'd1);
            check($sformatf("v%0d_t1_a", i), 32'(a), 32'(vecs[i].addr));
            check($sformatf("v%0d_t1_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_t1_phi_wr", i), {30'd0, phi, wr}, 32'd2);
            op = ~vecs[i].op; addr = ~vecs[i].addr; wdata = ~vecs[i].wdata;
            step();
            check($sformatf("v%0d_t2_rd_phi", i), {30'd0, rd, phi}, 32'd0);
            check($sformatf("v%0d_t2_wr", i), 32'(wr), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_t2_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("v%0d_t2_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("v%0d_t2_vld", i), {30'd0, fetch_vld, read_vld},
                  {30'd0, vecs[i].exp_fvld, vecs[i].exp_rvld});
            din = ~vecs[i].din;
            step();
            check($sformatf("v%0d_t3_m_end", i), 32'(m_end), 32'd1);
            check($sformatf("v%0d_t3_strobes", i), {30'd0, rd, wr}, 32'd0);
            check($sformatf("v%0d_t3_dout", i), 32'(dout), 32'd0);
            check($sformatf("v%0d_t3_vld", i), {30'd0, fetch_vld, read_vld}, 32'd0);
            check($sformatf("v%0d_t3_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("v%0d_t3_a", i), 32'(a), 32'(vecs[i].addr));
            op = 2'b00;
            step();
            check($sformatf("v%0d_end_t0", i), 32'(t_state), 32'd0);
            check($sformatf("v%0d_end_m_end", i), 32'(m_end), 32'd0);
        end

        // Ready low from T0 (must be ignored there) and for three clocks at T1
        op = 2'b11; addr = 16'h2468; din = 8'h5A; ready = 1'b0;
        step();
        check("w_t1", 32'(t_state), 32'd1);
`ifdef MCYCLE_SEQ_WAIT_EN
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("w_hold%0d_t", k), 32'(t_state), 32'd1);
            check($sformatf("w_hold%0d_rd_phi", k), {30'd0, rd, phi}, 32'd3);
            check($sformatf("w_hold%0d_a", k), 32'(a), 32'h2468);
        end
        ready = 1'b1; din = 8'h6B;
        step();
        check("w_t2", 32'(t_state), 32'd2);
        check("w_rdata", 32'(rdata), 32'h6B);
        check("w_read_vld", 32'(read_vld), 32'd1);
        ready = 1'b0;
        step();
        check("w_t3_m_end", {28'd0, t_state}, 32'd3);
        check("w_bus_err", 32'(bus_err), 32'd0);
`else
        step();
        check("nw_t2", 32'(t_state), 32'd2);
        check("nw_rdata", 32'(rdata), 32'h5A);
        check("nw_read_vld", 32'(read_vld), 32'd1);
        step();
        check("nw_t3", 32'(t_state), 32'd3);
        check("nw_bus_err", 32'(bus_err), 32'd0);
`endif
        check("w_m_end", 32'(m_end), 32'd1);
        op = 2'b00; ready = 1'b1;
        step();
        check("w_back_t0", 32'(t_state), 32'd0);

        // Six T-state instance: capture at T4, m_end at T5, late addr change ignored
        sync2();
        op2 = 2'b11; addr2 = 16'h4321; din2 = 8'h9C;
        step();
        check("t6_t1_a", 32'(a2), 32'h4321);
        check("t6_t1_rd", 32'(rd2), 32'd1);
        step();
        addr2 = 16'hDEAD; op2 = 2'b10;
        step();
        check("t6_t3_rd", 32'(rd2), 32'd1);
        check("t6_t3_vld", 32'(read_vld2), 32'd0);
        step();
        check("t6_t4_state", 32'(t_state2), 32'd4);
        check("t6_t4_rdata", 32'(rdata2), 32'h9C);
        check("t6_t4_vld_rd", {30'd0, read_vld2, rd2}, 32'd2);
        step();
        check("t6_t5_m_end", {27'd0, t_state2, m_end2}, {27'd0, 4'd5, 1'b1});
        check("t6_t5_a", 32'(a2), 32'h4321);
        step();
        check("t6_t0", 32'(t_state2), 32'd0);

        // Ready stuck low on the MAX_WAIT=2 instance
        op2 = 2'b11; addr2 = 16'h0777; din2 = 8'h42; ready2 = 1'b0;
        step(); step(); step();
        check("to_t3", 32'(t_state2), 32'd3);
`ifdef MCYCLE_SEQ_WAIT_EN
        step();
        check("to_hold1", 32'(t_state2), 32'd3);
        step();
        check("to_hold2", 32'(t_state2), 32'd3);
        check("to_err_before", 32'(bus_err2), 32'd0);
        step();
        check("to_t4", 32'(t_state2), 32'd4);
        check("to_err_set", 32'(bus_err2), 32'd1);
`else
        step();
        check("to_t4", 32'(t_state2), 32'd4);
        check("to_err_tied", 32'(bus_err2), 32'd0);
`endif
        check("to_rdata", 32'(rdata2), 32'h42);
        check("to_vld", 32'(read_vld2), 32'd1);
        op2 = 2'b00; ready2 = 1'b1;
        step(); step();
        check("to_back_t0", 32'(t_state2), 32'd0);
        repeat (6) step();
        check("to_next_len", 32'(t_state2), 32'd0);
`ifdef MCYCLE_SEQ_WAIT_EN
        check("to_err_sticky", 32'(bus_err2), 32'd1);
`else
        check("to_err_sticky", 32'(bus_err2), 32'd0);
`endif

        // Asynchronous reset during T2 of a write
        sync1();
        op = 2'b10; addr = 16'h3C3C; wdata = 8'h5C;
        step(); step();
        check("rw_t2_wr_dout", {23'd0, wr, dout}, {23'd0, 1'b1, 8'h5C});
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_async_wr_dout_phi", {22'd0, wr, phi, dout}, 32'd0);
        check("rw_async_t_a", {12'd0, t_state, a}, 32'd0);
        check("rw_async_err2", 32'(bus_err2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op = 2'b01; addr = 16'h0ABC; din = 8'h24;
        step();
        check("rw_after_t1", 32'(t_state), 32'd1);
        check("rw_after_a", 32'(a), 32'h0ABC);
        step();
        check("rw_after_rdata", 32'(rdata), 32'h24);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
